// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - byte request/serial status bundle for the UART transmitter
interface uart_transmitter_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_done;
  logic       bit_tick;

  modport master (
    output tx_data, tx_start,
    input  tx_ready, tx_serial, tx_done, bit_tick
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_ready, tx_serial, tx_done, bit_tick
  );
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter with registered serial line
// One byte per frame: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT clocks long.
module uart_transmitter #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic               clk_25mhz,
  input  logic               reset,
  uart_transmitter_if.slave  bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             serial_q, serial_n;
  logic             done_q, done_n;
  logic             last_clk;

  assign last_clk = (cnt == CNT_LAST);

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      serial_q <= serial_n;
      done_q   <= done_n;
    end
  end

  // serial_n is the line value for the next bit, so the output stays a flop
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    serial_n  = serial_q;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n    = '0;
        serial_n = 1'b1;
        if (bus.tx_start) begin
          shreg_n  = bus.tx_data;
          state_n  = START;
          serial_n = 1'b0;
        end
      end
      START: begin
        if (last_clk) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          serial_n  = shreg[0];
          state_n   = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (last_clk) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            serial_n = 1'b1;
            state_n  = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            serial_n  = shreg[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (last_clk) begin
          cnt_n    = '0;
          serial_n = 1'b1;
          done_n   = 1'b1;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n  = IDLE;
        cnt_n    = '0;
        serial_n = 1'b1;
      end
    endcase
  end

  assign bus.tx_ready  = (state == IDLE);
  assign bus.tx_serial = serial_q;
  assign bus.tx_done   = done_q;
  assign bus.bit_tick  = (state != IDLE) && last_clk;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter
// A line monitor decodes frames at bit centres and pops expected frames from a scoreboard queue.
module tb_uart_transmitter;
  localparam int CPB   = 217;
  localparam int FRAME = 10 * CPB;

  logic clk_25mhz = 1'b0;
  logic reset     = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   tick_cnt  = 0;
  int   done_cnt  = 0;
  int   frames    = 0;
  logic [3:0] last_4_bits = 4'hx;
  logic [9:0] exp_q[$];

  uart_transmitter_if u_if ();

  uart_transmitter #(.CLK_FREQ(25_000_000), .BAUD_RATE(115_200)) dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .bus       (u_if.slave)
  );

  always #5 clk_25mhz = ~clk_25mhz;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  always @(negedge clk_25mhz) begin
    if (u_if.bit_tick === 1'b1) tick_cnt <= tick_cnt + 1;
    if (u_if.tx_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line monitor: start bit detected at first low sample, then bit n sampled at offset 108 + n*217
  initial begin : monitor
    logic prev;
    logic [9:0] line;
    logic [9:0] exp_line;
    logic aborted;
    int wait_n;
    prev = 1'b1;
    forever begin
      @(negedge clk_25mhz);
      if (reset) begin
        prev = 1'b1;
        continue;
      end
      if (prev && u_if.tx_serial === 1'b0) begin
        aborted = 1'b0;
        line = '0;
        for (int n = 0; n < 10 && !aborted; n++) begin
          wait_n = (n == 0) ? (CPB / 2) : CPB;
          for (int k = 0; k < wait_n && !aborted; k++) begin
            @(negedge clk_25mhz);
            if (reset) aborted = 1'b1;
          end
          line[n] = u_if.tx_serial;
        end
        if (aborted) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          prev = 1'b1;
        end else begin
          frames++;
          last_4_bits = line[8:5];
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {22'd0, line}, 32'hFFFF_FFFF);
          end else begin
            exp_line = exp_q.pop_front();
            check("frame_bits", {22'd0, line}, {22'd0, exp_line});
          end
          prev = line[9];
        end
      end else begin
        prev = u_if.tx_serial;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [9:0] exp_line, output int c0);
    int k;
    k = 0;
    while (u_if.tx_ready !== 1'b1 && k < 5000) begin
      @(negedge clk_25mhz);
      k++;
    end
    check("ready_before_send", u_if.tx_ready, 1);
    u_if.tx_data  = d;
    u_if.tx_start = 1'b1;
    exp_q.push_back(exp_line);
    @(posedge clk_25mhz);
    #1;
    c0 = cyc;
    u_if.tx_start = 1'b0;
    u_if.tx_data  = ~d;
    check("ready_low_after_accept", u_if.tx_ready, 0);
  endtask

  task automatic wait_done(input int c0, input int budget, output int dt);
    dt = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_25mhz);
      if (u_if.tx_done === 1'b1) begin
        dt = cyc - c0;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
    logic [3:0] last4;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0, dt, dt2, t0, d0, f0;
    vecs[0] = '{8'hA5, 10'h34A, 4'hA};
    vecs[1] = '{8'hFF, 10'h3FE, 4'hF};
    vecs[2] = '{8'h00, 10'h200, 4'h0};
    vecs[3] = '{8'h81, 10'h302, 4'h8};
    vecs[4] = '{8'h3C, 10'h278, 4'h3};

    u_if.tx_data  = 8'h00;
    u_if.tx_start = 1'b0;
    #1 reset = 1'b1;
    repeat (10) begin
      @(negedge clk_25mhz);
      check("reset_held_outputs", {u_if.tx_serial, u_if.tx_ready, u_if.tx_done, u_if.bit_tick}, 4'b1100);
    end
    #2 reset = 1'b0;
    repeat (500) begin
      @(negedge clk_25mhz);
      check("idle_after_reset", {u_if.tx_serial, u_if.tx_ready, u_if.tx_done, u_if.bit_tick}, 4'b1100);
    end

    foreach (vecs[i]) begin
      t0 = tick_cnt;
      d0 = done_cnt;
      f0 = frames;
      send(vecs[i].data, vecs[i].line, c0);
      wait_done(c0, FRAME + 100, dt);
      check("frame_len_to_done", dt, FRAME);
      check("ready_in_done_cycle", u_if.tx_ready, 1);
      repeat (20) @(negedge clk_25mhz);
      check("bit_tick_count", tick_cnt - t0, 10);
      check("tx_done_count", done_cnt - d0, 1);
      check("frames_decoded", frames - f0, 1);
      check("sampler_last_4_bits", last_4_bits, vecs[i].last4);
    end

    // Ignored request mid-frame
    d0 = done_cnt;
    f0 = frames;
    send(8'h3C, 10'h278, c0);
    while (cyc - c0 < 500) @(negedge clk_25mhz);
    check("busy_ready_low", u_if.tx_ready, 0);
    u_if.tx_data  = 8'hFF;
    u_if.tx_start = 1'b1;
    @(posedge clk_25mhz);
    #1 u_if.tx_start = 1'b0;
    wait_done(c0, FRAME + 100, dt);
    check("ignored_start_frame_len", dt, FRAME);
    repeat (FRAME + 100) @(negedge clk_25mhz);
    check("ignored_start_done_count", done_cnt - d0, 1);
    check("ignored_start_frames", frames - f0, 1);
    check("ignored_start_line_idle", u_if.tx_serial, 1);

    // Back-to-back: start held high through tx_done
    f0 = frames;
    u_if.tx_data  = 8'h00;
    u_if.tx_start = 1'b1;
    exp_q.push_back(10'h200);
    exp_q.push_back(10'h3FE);
    @(posedge clk_25mhz);
    #1 c0 = cyc;
    u_if.tx_data = 8'hFF;
    wait_done(c0, FRAME + 100, dt);
    check("b2b_first_done", dt, FRAME);
    @(posedge clk_25mhz);
    #1 u_if.tx_start = 1'b0;
    check("b2b_second_start_bit", u_if.tx_serial, 0);
    check("b2b_ready_low", u_if.tx_ready, 0);
    wait_done(c0, 2 * FRAME + 100, dt2);
    check("b2b_second_done", dt2, 2 * FRAME + 1);
    repeat (20) @(negedge clk_25mhz);
    check("b2b_frames", frames - f0, 2);
    check("b2b_last_4_bits", last_4_bits, 4'hF);

    // Asynchronous reset mid-frame, then immediate new byte
    send(8'h55, 10'h2AA, c0);
    while (cyc - c0 < 1000) @(negedge clk_25mhz);
    d0 = done_cnt;
    f0 = frames;
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {u_if.tx_serial, u_if.tx_ready, u_if.tx_done, u_if.bit_tick}, 4'b1100);
    repeat (3) @(negedge clk_25mhz);
    #2 reset = 1'b0;
    check("abort_no_done", done_cnt - d0, 0);
    u_if.tx_data  = 8'h81;
    u_if.tx_start = 1'b1;
    exp_q.push_back(10'h302);
    @(posedge clk_25mhz);
    #1 c0 = cyc;
    u_if.tx_start = 1'b0;
    check("accept_after_reset", u_if.tx_ready, 0);
    wait_done(c0, FRAME + 100, dt);
    check("post_reset_frame_len", dt, FRAME);
    repeat (20) @(negedge clk_25mhz);
    check("post_reset_done_count", done_cnt - d0, 1);
    check("post_reset_frames", frames - f0, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
